// File: rtl/e203_nice_csr_bridge_pkg.sv
// ---------------------------------------------------------------------------
// e203_nice_csr_pkg
// Shared types and constants for the NICE CSR bridge.
//   - state_t     : bridge FSM state (IDLE / REQ / RSP), 2 bits
//   - CSR_IDX_W   : CSR index width (12)
//   - DATA_W      : CSR data width (32)
//   - *_DEF       : default window base/mask and request timeout
//   - idx_in_range: window decode helper
// Optional feature macro used by the bridge: E203_NICE_CSR_TIMEOUT_EN
// ---------------------------------------------------------------------------
package e203_nice_csr_pkg;

    localparam int CSR_IDX_W = 12;
    localparam int DATA_W    = 32;

    localparam logic [CSR_IDX_W-1:0] CSR_BASE_DEF    = 12'hBC0;
    localparam logic [CSR_IDX_W-1:0] CSR_MASK_DEF    = 12'hFC0;
    localparam int                   TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // An index belongs to the window when its masked bits equal the base.
    function automatic logic idx_in_range(
        input logic [CSR_IDX_W-1:0] idx,
        input logic [CSR_IDX_W-1:0] base,
        input logic [CSR_IDX_W-1:0] mask
    );
        return ((idx & mask) == base);
    endfunction

endpackage

// File: rtl/e203_nice_csr_bridge_if.sv
// ---------------------------------------------------------------------------
// e203_nice_csr_bridge_if
// Bundles the three channels around the bridge:
//   command  : cmd_valid/cmd_ready, cmd_idx, cmd_wr, cmd_wdata   (core -> bridge)
//   response : rsp_valid/rsp_ready, rsp_rdata, rsp_err           (bridge -> core)
//   NICE CSR : nice_csr_valid/ready, addr, wr, wdata, rdata      (bridge <-> NICE)
// Modports:
//   master : the environment (core CSR unit plus NICE CSR block)
//   slave  : the bridge itself
//
// Handshake rule for all three channels: a transfer happens in a cycle where
// valid and ready are both high at the rising clock edge. Once valid is high
// the payload stays stable until that transfer (or, on the NICE channel, an
// abort). valid never depends combinationally on ready.
// ---------------------------------------------------------------------------
interface e203_nice_csr_bridge_if;
    import e203_nice_csr_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CSR_IDX_W-1:0] cmd_idx;
    logic                 cmd_wr;
    logic [DATA_W-1:0]    cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_W-1:0]    rsp_rdata;
    logic                 rsp_err;

    logic                 nice_csr_valid;
    logic                 nice_csr_ready;
    logic [DATA_W-1:0]    nice_csr_addr;
    logic                 nice_csr_wr;
    logic [DATA_W-1:0]    nice_csr_wdata;
    logic [DATA_W-1:0]    nice_csr_rdata;

    modport master (
        output cmd_valid, cmd_idx, cmd_wr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata,
        output nice_csr_ready, nice_csr_rdata
    );

    modport slave (
        input  cmd_valid, cmd_idx, cmd_wr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata,
        input  nice_csr_ready, nice_csr_rdata
    );

endinterface

// File: rtl/e203_nice_csr_bridge_tmr.sv
// ---------------------------------------------------------------------------
// e203_nice_csr_tmr
// Request timeout down-counter.
//   clk, rst_n : clock, asynchronous active-low reset (count resets to 0)
//   i_clr      : load TIMEOUT_CYC-1 (start of a new request)
//   i_en       : count down one step (waiting cycle without ready)
//   o_expire   : count is zero, i.e. this is the last allowed waiting cycle
// Loading TIMEOUT_CYC-1 makes o_expire rise in the TIMEOUT_CYC-th cycle of a
// request, so the request is visible for exactly TIMEOUT_CYC cycles.
// ---------------------------------------------------------------------------
module e203_nice_csr_tmr #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int                CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= LOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/e203_nice_csr_bridge.sv
// ---------------------------------------------------------------------------
// e203_nice_csr_bridge
// Feeds the NICE CSR handshake port from custom-CSR commands of the core.
// A command is range-checked against the NICE window; in-range commands are
// forwarded as a single held request on nice_csr_*, out-of-range commands are
// answered directly with an error. The response is buffered until the core
// takes it, and only then is the next command accepted.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : e203_nice_csr_bridge_if.slave (command/response/NICE channels)
//   busy       : FSM not in IDLE
//   dbg_state  : current FSM state
// Parameters: CSR_BASE, CSR_MASK (window decode), TIMEOUT_CYC (2..256).
// Optional feature: E203_NICE_CSR_TIMEOUT_EN enables the request timeout;
// without it a request waits for nice_csr_ready indefinitely.
// ---------------------------------------------------------------------------
module e203_nice_csr_bridge
    import e203_nice_csr_pkg::*;
#(
    parameter logic [CSR_IDX_W-1:0] CSR_BASE    = CSR_BASE_DEF,
    parameter logic [CSR_IDX_W-1:0] CSR_MASK    = CSR_MASK_DEF,
    parameter int                   TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    e203_nice_csr_bridge_if.slave    bus,
    output logic                     busy,
    output state_t                   dbg_state
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [CSR_IDX_W-1:0] r_idx;
    logic                 r_wr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;

    logic                 w_in_range;
    logic                 w_accept;
    logic                 w_nice_hs;
    logic                 w_tmo_abort;

    assign w_in_range = idx_in_range(bus.cmd_idx, CSR_BASE, CSR_MASK);
    assign w_accept   = (r_state == IDLE) && bus.cmd_valid;
    assign w_nice_hs  = (r_state == REQ) && bus.nice_csr_ready;

`ifdef E203_NICE_CSR_TIMEOUT_EN
    logic w_tmr_expire;

    e203_nice_csr_tmr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_accept && w_in_range),
        .i_en     ((r_state == REQ) && !bus.nice_csr_ready),
        .o_expire (w_tmr_expire)
    );

    // A ready arriving in the final cycle is a normal handshake, not an abort.
    assign w_tmo_abort = (r_state == REQ) && !bus.nice_csr_ready && w_tmr_expire;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC == 0);
    assign w_tmo_abort  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_state_nxt = w_in_range ? REQ : RSP;
                end
            end
            REQ: begin
                if (bus.nice_csr_ready || w_tmo_abort) begin
                    w_state_nxt = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (state-only, so no valid depends on a ready)
    // ------------------------------------------------------------------
    always_comb begin
        bus.cmd_ready      = 1'b0;
        bus.nice_csr_valid = 1'b0;
        bus.rsp_valid      = 1'b0;
        busy               = 1'b1;
        unique case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
            end
            REQ:     bus.nice_csr_valid = 1'b1;
            RSP:     bus.rsp_valid      = 1'b1;
            default: busy               = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: command latches and response buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= bus.cmd_idx;
            r_wr    <= bus.cmd_wr;
            r_wdata <= bus.cmd_wdata;
            r_rdata <= '0;
            // Out-of-range commands skip REQ, so their error is known now.
            r_err   <= !w_in_range;
        end else if (w_nice_hs) begin
            // Captured for writes too; the NICE block defines what it returns.
            r_rdata <= bus.nice_csr_rdata;
            r_err   <= 1'b0;
        end else if (w_tmo_abort) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end
    end

    assign bus.nice_csr_addr  = {{(DATA_W-CSR_IDX_W){1'b0}}, r_idx};
    assign bus.nice_csr_wr    = r_wr;
    assign bus.nice_csr_wdata = r_wdata;
    assign bus.rsp_rdata      = r_rdata;
    assign bus.rsp_err        = r_err;
    assign dbg_state          = r_state;

endmodule
